tsense_conv_scheduler: RTL and testbench

Schedules temperature-sensor conversions across NCH sensing channels that share one switched-capacitor front-end and one comparator. Picks the next enabled channel round-robin and holds the front-end in precharge for a settle window. It then counts comparator decisions over a fixed sample window and presents the ones-count as the conversion result through a valid/ready handshake. Sits between the register/bus interface (above) and the phase-generating front-end sequencer (below).

---
 rtl/tsense_pkg.sv | 20 ++
 rtl/tsense_rr_pick.sv | 29 ++
 rtl/tsense_conv_scheduler.sv | 173 +++++++++++++++++
 tb/tb_tsense_conv_scheduler.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tsense_pkg.sv
// Shared types and helpers for the temperature-sensor conversion scheduler.
package tsense_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SETTLE,
        S_CONVERT,
        S_OUTPUT
    } state_t;

    localparam int unsigned WIN_DEF    = 256;
    localparam int unsigned SETTLE_DEF = 8;

    // Field width able to index/count n distinct values (minimum one bit).
    function automatic int unsigned fld_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tsense_rr_pick.sv
// Round-robin picker: first set mask bit strictly after ptr, wrapping around.
module tsense_rr_pick
    import tsense_pkg::*;
#(
    parameter  int unsigned NCH = 4,
    localparam int unsigned CW  = fld_width(NCH)
) (
    input  logic [NCH-1:0] mask,
    input  logic [CW-1:0]  ptr,
    output logic [CW-1:0]  idx,
    output logic           found
);

    logic [CW-1:0] cand;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            cand = CW'((32'(ptr) + k + 1) % NCH);
            if (!found && mask[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/tsense_conv_scheduler.sv
// Schedules sensor-channel conversions over a shared front-end and comparator,
// counting comparator ones per window and handing results out via valid/ready.
module tsense_conv_scheduler
    import tsense_pkg::*;
#(
    parameter  int unsigned NCH    = 4,
    parameter  int unsigned WIN    = WIN_DEF,
    parameter  int unsigned SETTLE = SETTLE_DEF,
    localparam int unsigned CW     = fld_width(NCH),
    localparam int unsigned DW     = fld_width(WIN + 1),
    localparam int unsigned NW     = fld_width(WIN),
    localparam int unsigned SW     = fld_width(SETTLE)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] en_mask,
    input  logic           trigger,
    input  logic           continuous,
    input  logic           abort,
    input  logic           smp_valid,
    input  logic           smp_bit,
    output logic           fe_en,
    output logic           fe_rst,
    output logic [CW-1:0]  fe_ch,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [DW-1:0]  res_data,
    output logic [CW-1:0]  res_ch,
    output logic           busy
);

    state_t         state_q, state_n;
    logic [CW-1:0]  ptr_q, ptr_n, fe_ch_n, res_ch_n;
    logic [NCH-1:0] pass_q, pass_n;
    logic [SW-1:0]  scnt_q, scnt_n;
    logic [NW-1:0]  nsamp_q, nsamp_n;
    logic [DW-1:0]  ones_q, ones_n, res_data_n;
    logic           res_valid_n, abort_pend_q, abort_pend_n;
    logic [NCH-1:0] cand_mask;
    logic [CW-1:0]  pick_idx;
    logic           pick_found;

    assign cand_mask = continuous ? en_mask : pass_q;

    tsense_rr_pick #(.NCH(NCH)) u_pick (
        .mask  (cand_mask),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        state_n      = state_q;
        ptr_n        = ptr_q;
        pass_n       = pass_q;
        scnt_n       = scnt_q;
        nsamp_n      = nsamp_q;
        ones_n       = ones_q;
        fe_ch_n      = fe_ch;
        res_data_n   = res_data;
        res_ch_n     = res_ch;
        res_valid_n  = res_valid;
        abort_pend_n = abort_pend_q;

        unique case (state_q)
            S_IDLE: begin
                if (!abort && (trigger || continuous) && (en_mask != '0)) begin
                    state_n = S_SELECT;
                    if (trigger) pass_n = en_mask;
                end
            end
            S_SELECT: begin
                if (abort) begin
                    state_n = S_IDLE;
                    pass_n  = '0;
                end else if (pick_found) begin
                    fe_ch_n = pick_idx;
                    ptr_n   = pick_idx;
                    pass_n  = pass_q & ~(NCH'(1) << pick_idx);
                    scnt_n  = '0;
                    state_n = S_SETTLE;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_n = S_IDLE;
                    pass_n  = '0;
                    scnt_n  = '0;
                end else if (scnt_q == SW'(SETTLE - 1)) begin
                    state_n = S_CONVERT;
                    nsamp_n = '0;
                    ones_n  = '0;
                end else begin
                    scnt_n = scnt_q + SW'(1);
                end
            end
            S_CONVERT: begin
                if (abort) begin
                    state_n = S_IDLE;
                    pass_n  = '0;
                    nsamp_n = '0;
                    ones_n  = '0;
                end else if (smp_valid) begin
                    if (nsamp_q == NW'(WIN - 1)) begin
                        state_n     = S_OUTPUT;
                        res_data_n  = ones_q + DW'(smp_bit);
                        res_ch_n    = fe_ch;
                        res_valid_n = 1'b1;
                        nsamp_n     = '0;
                        ones_n      = '0;
                    end else begin
                        nsamp_n = nsamp_q + NW'(1);
                        ones_n  = ones_q + DW'(smp_bit);
                    end
                end
            end
            S_OUTPUT: begin
                // abort here is deferred until the pending result is consumed
                if (abort) abort_pend_n = 1'b1;
                if (res_ready) begin
                    res_valid_n = 1'b0;
                    if (abort || abort_pend_q) begin
                        state_n      = S_IDLE;
                        pass_n       = '0;
                        abort_pend_n = 1'b0;
                    end else if (continuous || (pass_q != '0)) begin
                        state_n = S_SELECT;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ptr_q        <= CW'(NCH - 1);
            pass_q       <= '0;
            scnt_q       <= '0;
            nsamp_q      <= '0;
            ones_q       <= '0;
            abort_pend_q <= 1'b0;
            fe_en        <= 1'b0;
            fe_rst       <= 1'b0;
            fe_ch        <= '0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_ch       <= '0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_n;
            ptr_q        <= ptr_n;
            pass_q       <= pass_n;
            scnt_q       <= scnt_n;
            nsamp_q      <= nsamp_n;
            ones_q       <= ones_n;
            abort_pend_q <= abort_pend_n;
            fe_en        <= (state_n == S_SETTLE) || (state_n == S_CONVERT);
            fe_rst       <= (state_n == S_SETTLE);
            fe_ch        <= fe_ch_n;
            res_valid    <= res_valid_n;
            res_data     <= res_data_n;
            res_ch       <= res_ch_n;
            busy         <= (state_n != S_IDLE);
        end
    end

endmodule

// File: tb/tb_tsense_conv_scheduler.sv
// Directed self-checking bench for tsense_conv_scheduler (NCH=4, WIN=256, SETTLE=8).
module tb_tsense_conv_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] en_mask;
    logic       trigger, continuous, abort;
    logic       smp_valid, smp_bit, res_ready;
    logic       fe_en, fe_rst, res_valid, busy;
    logic [1:0] fe_ch, res_ch;
    logic [8:0] res_data;

    int n_cmp = 0;
    int n_err = 0;
    int smp_mode = 0;

    always #5 clk = ~clk;

    tsense_conv_scheduler #(.NCH(4), .WIN(256), .SETTLE(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .en_mask    (en_mask),
        .trigger    (trigger),
        .continuous (continuous),
        .abort      (abort),
        .smp_valid  (smp_valid),
        .smp_bit    (smp_bit),
        .fe_en      (fe_en),
        .fe_rst     (fe_rst),
        .fe_ch      (fe_ch),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_ch     (res_ch),
        .busy       (busy)
    );

    // Comparator stream: mode 1 = strobe every other cycle, alternating bit; mode 2 = all ones every cycle.
    initial begin
        logic phase;
        phase     = 1'b0;
        smp_valid = 1'b0;
        smp_bit   = 1'b0;
        forever begin
            @(negedge clk);
            case (smp_mode)
                1: begin
                    phase     = ~phase;
                    smp_valid = phase;
                    if (phase) smp_bit = ~smp_bit;
                end
                2: begin
                    smp_valid = 1'b1;
                    smp_bit   = 1'b1;
                end
                default: smp_valid = 1'b0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic settle_phase(input string tag, input logic [1:0] exp_ch);
        int len = 0;
        for (int i = 0; i < 40 && !fe_rst; i++) tick();
        check_eq({tag, "_rst_seen"}, 32'(fe_rst), 1);
        check_eq({tag, "_ch"}, 32'(fe_ch), 32'(exp_ch));
        for (int i = 0; i < 40 && fe_rst; i++) begin
            len++;
            tick();
        end
        check_eq({tag, "_rst_len"}, len, 8);
        check_eq({tag, "_conv_en"}, 32'(fe_en), 1);
    endtask

    task automatic get_result(input string tag, input logic [1:0] exp_ch, input logic [8:0] exp_data);
        for (int i = 0; i < 2000 && !res_valid; i++) tick();
        check_eq({tag, "_valid"}, 32'(res_valid), 1);
        check_eq({tag, "_ch"}, 32'(res_ch), 32'(exp_ch));
        check_eq({tag, "_data"}, 32'(res_data), 32'(exp_data));
    endtask

    task automatic accept(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check_eq({tag, "_vld_clr"}, 32'(res_valid), 0);
    endtask

    task automatic wait_convert();
        for (int i = 0; i < 40 && !(fe_en && !fe_rst); i++) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt, changes, seen;
        logic [8:0] hd;
        logic [1:0] hc;

        reset = 1'b1; en_mask = '0; trigger = 0; continuous = 0; abort = 0; res_ready = 0;
        tick(); tick();
        check_eq("rst_fe_en", 32'(fe_en), 0);
        check_eq("rst_fe_rst", 32'(fe_rst), 0);
        check_eq("rst_fe_ch", 32'(fe_ch), 0);
        check_eq("rst_res_valid", 32'(res_valid), 0);
        check_eq("rst_res_data", 32'(res_data), 0);
        check_eq("rst_res_ch", 32'(res_ch), 0);
        check_eq("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        tick();

        // Single pass over ch1, ch3 with alternating comparator bits
        smp_mode = 1; en_mask = 4'b1010; trigger = 1;
        tick();
        trigger = 0;
        check_eq("t1_sel_busy", 32'(busy), 1);
        check_eq("t1_sel_rst", 32'(fe_rst), 0);
        settle_phase("t1a", 2'd1);
        get_result("t1a", 2'd1, 9'd128);
        accept("t1a");
        settle_phase("t1b", 2'd3);
        get_result("t1b", 2'd3, 9'd128);
        accept("t1b");
        tick();
        check_eq("t1_idle_busy", 32'(busy), 0);
        check_eq("t1_idle_fe_en", 32'(fe_en), 0);

        // Empty mask trigger is ignored
        en_mask = 4'b0000; trigger = 1;
        tick();
        trigger = 0;
        check_eq("t0_busy", 32'(busy), 0);
        tick();
        check_eq("t0_busy2", 32'(busy), 0);

        // Continuous loop, all ones, with a 50-cycle stall on the first result
        smp_mode = 2; en_mask = 4'b1111; continuous = 1;
        get_result("t2_r0", 2'd0, 9'd256);
        hd = res_data; hc = res_ch; changes = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (res_valid !== 1'b1 || res_data !== hd || res_ch !== hc || fe_en !== 1'b0) changes++;
        end
        check_eq("t2_hold_changes", changes, 0);
        accept("t2_r0");
        get_result("t2_r1", 2'd1, 9'd256);
        accept("t2_r1");
        get_result("t2_r2", 2'd2, 9'd256);
        accept("t2_r2");
        get_result("t2_r3", 2'd3, 9'd256);
        accept("t2_r3");
        get_result("t2_r4", 2'd0, 9'd256);
        continuous = 0;
        accept("t2_r4");
        tick();
        check_eq("t2_idle_busy", 32'(busy), 0);

        // Abort on the 100th accepted sample of ch1
        smp_mode = 1; en_mask = 4'b1111; trigger = 1;
        tick();
        trigger = 0;
        wait_convert();
        check_eq("t3_conv_ch", 32'(fe_ch), 1);
        cnt = 0;
        for (int i = 0; i < 1000 && cnt < 100; i++) begin
            if (smp_valid) cnt++;
            if (cnt == 100) abort = 1;
            tick();
        end
        abort = 0;
        check_eq("t3_abort_busy", 32'(busy), 0);
        check_eq("t3_abort_fe_en", 32'(fe_en), 0);
        check_eq("t3_abort_fe_rst", 32'(fe_rst), 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (res_valid) seen++;
            tick();
        end
        check_eq("t3_no_result", seen, 0);

        // Restart after abort resumes at ch2; drop ch2 from the live mask mid-conversion
        smp_mode = 2; continuous = 1; trigger = 1;
        tick();
        trigger = 0;
        wait_convert();
        check_eq("t4_conv_ch", 32'(fe_ch), 2);
        en_mask = 4'b1011;
        get_result("t4_r2", 2'd2, 9'd256);
        accept("t4_r2");
        get_result("t4_r3", 2'd3, 9'd256);
        accept("t4_r3");
        get_result("t4_r0", 2'd0, 9'd256);
        accept("t4_r0");
        get_result("t4_r1", 2'd1, 9'd256);
        accept("t4_r1");
        get_result("t4_skip", 2'd3, 9'd256);
        abort = 1;
        tick();
        abort = 0;
        tick();
        check_eq("t4_abort_hold", 32'(res_valid), 1);
        accept("t4_abort");
        check_eq("t4_abort_idle", 32'(busy), 0);
        continuous = 0;
        tick();
        check_eq("t4_stay_idle", 32'(busy), 0);

        // Reset during SETTLE
        en_mask = 4'b1100; trigger = 1;
        tick();
        trigger = 0;
        for (int i = 0; i < 10 && !fe_rst; i++) tick();
        check_eq("t5_settle_ch", 32'(fe_ch), 2);
        #2 reset = 1;
        #1;
        check_eq("t5_rs_fe_en", 32'(fe_en), 0);
        check_eq("t5_rs_fe_rst", 32'(fe_rst), 0);
        check_eq("t5_rs_fe_ch", 32'(fe_ch), 0);
        check_eq("t5_rs_busy", 32'(busy), 0);
        tick();
        reset = 0;
        en_mask = 4'b1111; trigger = 1;
        tick();
        trigger = 0;
        settle_phase("t5a", 2'd0);
        get_result("t5a", 2'd0, 9'd256);

        // Reset during OUTPUT
        #2 reset = 1;
        #1;
        check_eq("t5_ro_valid", 32'(res_valid), 0);
        check_eq("t5_ro_data", 32'(res_data), 0);
        check_eq("t5_ro_ch", 32'(res_ch), 0);
        check_eq("t5_ro_busy", 32'(busy), 0);
        tick();
        reset = 0;
        trigger = 1;
        tick();
        trigger = 0;
        settle_phase("t5b", 2'd0);
        abort = 1;
        tick();
        abort = 0;
        check_eq("t5_end_busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
